// File: rtl/signed_bcd_formatter_pkg.sv
// Shared constants and types for the signed BCD display formatter.
// Digit codes are shared with the 7-segment multiplexer stage downstream.
package signed_bcd_formatter_pkg;

    // Number of display digits driven by the formatter.
    localparam int DECIMAL_DIGITS = 4;

    // Width of the packed digit field that carries real data.
    localparam int BCD_W = DECIMAL_DIGITS * 4;

    // Width of the BCD output bus; bits above BCD_W are always zero.
    localparam int OUT_W = DECIMAL_DIGITS * 8;

    // Special digit codes understood by the indicator.
    localparam logic [3:0] BCD_MINUS = 4'hF;
    localparam logic [3:0] BCD_BLANK = 4'hA;

    // Saturation limits: a negative number needs one digit for the minus sign.
    localparam int POS_LIMIT = 9999;
    localparam int NEG_LIMIT = 999;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_FORMAT = 2'd3
    } fsm_state_t;

    // Display pattern shown after reset: "   0" with blanking, "0000" without.
    function automatic logic [BCD_W-1:0] reset_display(input bit blank_leading);
        logic [BCD_W-1:0] r;
        r = '0;
        if (blank_leading) begin
            for (int k = 1; k < DECIMAL_DIGITS; k++) begin
                r[k*4 +: 4] = BCD_BLANK;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/signed_bcd_formatter_if.sv
// Request/result bundle between the sensor decoder and the BCD formatter.
// The master side issues conversions, the slave side (formatter) answers.
interface signed_bcd_formatter_if #(
    parameter int DATA_WIDTH = 16
) ();

    logic                                        start_i;
    logic [DATA_WIDTH-1:0]                       value_i;
    logic                                        busy_o;
    logic                                        done_o;
    logic                                        ovf_o;
    logic [signed_bcd_formatter_pkg::OUT_W-1:0]  BCD_o;

    modport master (
        output start_i,
        output value_i,
        input  busy_o,
        input  done_o,
        input  ovf_o,
        input  BCD_o
    );

    modport slave (
        input  start_i,
        input  value_i,
        output busy_o,
        output done_o,
        output ovf_o,
        output BCD_o
    );

endinterface

// File: rtl/signed_bcd_formatter_digit_adj.sv
// Double-dabble correction for one BCD nibble: a digit of 5 or more gets +3
// so that the following left shift carries correctly into the next decade.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/signed_bcd_formatter.sv
// Signed two's-complement to 4-digit display code converter.
// Iterative double-dabble core followed by sign, saturation and leading-zero
// blanking. The display register only updates when a conversion finishes.
module signed_bcd_formatter
    import signed_bcd_formatter_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    signed_bcd_formatter_if.slave bus
);

    // Sequencer and datapath registers.
    fsm_state_t            state_reg, state_next;
    logic [DATA_WIDTH-1:0] value_reg, value_next;
    logic                  sign_reg, sign_next;
    logic                  ovf_pend_reg, ovf_pend_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [BCD_W-1:0]      acc_reg, acc_next;
    logic [4:0]            cnt_reg, cnt_next;

    // Output registers.
    logic [BCD_W-1:0]      disp_reg, disp_next;
    logic                  ovf_reg, ovf_next;
    logic                  done_reg, done_next;

    // LOAD datapath: magnitude one bit wider so the most negative value fits.
    logic                  val_sign;
    logic [DATA_WIDTH:0]   mag;
    logic [31:0]           lim;
    logic                  clamp_hit;

    // SHIFT datapath.
    logic [BCD_W-1:0]            acc_adj;
    logic [BCD_W+DATA_WIDTH-1:0] dabble_shifted;

    // FORMAT datapath.
    logic [2:0]            msd;
    logic [BCD_W-1:0]      disp_fmt;

    // One correction unit per decade of the accumulator.
    genvar gi;
    generate
        for (gi = 0; gi < DECIMAL_DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit    (acc_reg[gi*4 +: 4]),
                .adjusted (acc_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // Shift the corrected accumulator and the remaining binary bits as one word.
    assign dabble_shifted = {acc_adj, shift_reg} << 1;

    // Sign, magnitude and saturation of the captured value.
    always_comb begin
        val_sign  = value_reg[DATA_WIDTH-1];
        mag       = val_sign ? ((~{1'b1, value_reg}) + (DATA_WIDTH+1)'(1))
                             : {1'b0, value_reg};
        lim       = val_sign ? 32'(NEG_LIMIT) : 32'(POS_LIMIT);
        clamp_hit = (32'(mag) > lim);
    end

    // Locate the most significant nonzero digit; digit 0 is always shown.
    always_comb begin
        msd = '0;
        for (int k = 0; k < DECIMAL_DIGITS; k++) begin
            if (acc_reg[k*4 +: 4] != 4'h0) begin
                msd = 3'(k);
            end
        end
    end

    // Apply blanking and place the minus sign on the finished digits.
    always_comb begin
        disp_fmt = acc_reg;
        if (BLANK_LEADING) begin
            for (int k = 0; k < DECIMAL_DIGITS; k++) begin
                if (k > int'(msd)) begin
                    if (sign_reg && (k == int'(msd) + 1)) begin
                        disp_fmt[k*4 +: 4] = BCD_MINUS;
                    end else begin
                        disp_fmt[k*4 +: 4] = BCD_BLANK;
                    end
                end
            end
        end else if (sign_reg) begin
            // Clamp keeps negative magnitudes below 1000, so the top digit is free.
            disp_fmt[BCD_W-1 -: 4] = BCD_MINUS;
        end
    end

    // Next-state and datapath update for the conversion sequencer.
    always_comb begin
        state_next    = state_reg;
        value_next    = value_reg;
        sign_next     = sign_reg;
        ovf_pend_next = ovf_pend_reg;
        shift_next    = shift_reg;
        acc_next      = acc_reg;
        cnt_next      = cnt_reg;
        disp_next     = disp_reg;
        ovf_next      = ovf_reg;
        done_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start_i) begin
                    value_next = bus.value_i;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sign_next     = val_sign;
                ovf_pend_next = clamp_hit;
                shift_next    = clamp_hit ? DATA_WIDTH'(lim) : mag[DATA_WIDTH-1:0];
                acc_next      = '0;
                cnt_next      = '0;
                state_next    = ST_SHIFT;
            end
            ST_SHIFT: begin
                acc_next   = dabble_shifted[BCD_W+DATA_WIDTH-1:DATA_WIDTH];
                shift_next = dabble_shifted[DATA_WIDTH-1:0];
                if (cnt_reg == 5'(DATA_WIDTH - 1)) begin
                    state_next = ST_FORMAT;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
            ST_FORMAT: begin
                disp_next  = disp_fmt;
                ovf_next   = ovf_pend_reg;
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            value_reg    <= '0;
            sign_reg     <= 1'b0;
            ovf_pend_reg <= 1'b0;
            shift_reg    <= '0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            disp_reg     <= reset_display(BLANK_LEADING);
            ovf_reg      <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            value_reg    <= value_next;
            sign_reg     <= sign_next;
            ovf_pend_reg <= ovf_pend_next;
            shift_reg    <= shift_next;
            acc_reg      <= acc_next;
            cnt_reg      <= cnt_next;
            disp_reg     <= disp_next;
            ovf_reg      <= ovf_next;
            done_reg     <= done_next;
        end
    end

    assign bus.busy_o = (state_reg != ST_IDLE);
    assign bus.done_o = done_reg;
    assign bus.ovf_o  = ovf_reg;
    assign bus.BCD_o  = {{(OUT_W-BCD_W){1'b0}}, disp_reg};

endmodule

// File: tb/tb_signed_bcd_formatter.sv
// Randomized scoreboard bench for signed_bcd_formatter. Two instances run in
// lockstep, one with leading-zero blanking and one without.
module tb_signed_bcd_formatter;
    import signed_bcd_formatter_pkg::*;

    localparam int DW     = 16;
    localparam int LAT    = DW + 2;
    localparam int PERIOD = DW + 3;

    typedef struct {
        logic [DW-1:0] v;
        logic [31:0]   bcd;
        logic          ovf;
        int            acc_edge;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] value = '0;
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_fail   = 0;

    exp_t          exp_q [2][$];
    logic [1:0]    busy_w, done_w, ovf_w;
    logic [31:0]   bcd_w [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        signed_bcd_formatter_if #(.DATA_WIDTH(DW)) bus ();
        signed_bcd_formatter #(
            .DATA_WIDTH    (DW),
            .BLANK_LEADING (gi == 0)
        ) dut (
            .clk (clk),
            .rst (rst_n),
            .bus (bus)
        );
        assign bus.start_i = start;
        assign bus.value_i = value;
        assign busy_w[gi]  = bus.busy_o;
        assign done_w[gi]  = bus.done_o;
        assign ovf_w[gi]   = bus.ovf_o;
        assign bcd_w[gi]   = bus.BCD_o;
    end

    task automatic check(input string name, input int dut, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h", name, dut, act, exp);
        end
    endtask

    // Reference: decimal digits by division, then blank/sign rules.
    function automatic exp_t model(input logic [DW-1:0] v, input bit bl, input int acc_edge);
        exp_t       r;
        int         sv, m, lim, nd;
        bit         neg;
        logic [3:0] d [4];
        int         p10 [4] = '{1, 10, 100, 1000};
        sv    = int'($signed(v));
        neg   = (sv < 0);
        m     = neg ? -sv : sv;
        lim   = neg ? 999 : 9999;
        r.ovf = (m > lim);
        if (m > lim) m = lim;
        nd = 1;
        for (int k = 1; k < 4; k++) if (m >= p10[k]) nd = k + 1;
        for (int k = 0; k < 4; k++) d[k] = 4'((m / p10[k]) % 10);
        if (bl) begin
            for (int k = 0; k < 4; k++) if (k >= nd) d[k] = 4'hA;
            if (neg) d[nd] = 4'hF;
        end else if (neg) begin
            d[3] = 4'hF;
        end
        r.bcd      = {16'h0, d[3], d[2], d[1], d[0]};
        r.v        = v;
        r.acc_edge = acc_edge;
        return r;
    endfunction

    task automatic push_exp(input logic [DW-1:0] v);
        for (int i = 0; i < 2; i++) exp_q[i].push_back(model(v, i == 0, cyc + 1));
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy_w != 2'b00 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait", 0, 32'(busy_w), 32'd0);
    endtask

    task automatic do_conv(input logic [DW-1:0] v);
        wait_idle();
        start = 1'b1;
        value = v;
        push_exp(v);
        @(negedge clk);
        start = 1'b0;
        value = DW'($urandom);
    endtask

    function automatic logic [DW-1:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return DW'($urandom);
            1:       return DW'($urandom_range(0, 120));
            2:       return DW'(-int'($urandom_range(0, 1200)));
            default: return DW'($urandom_range(9000, 11000));
        endcase
    endfunction

    // Monitor: pops one expectation per done pulse and compares.
    initial begin
        int   busy_run [2] = '{0, 0};
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    busy_run[i] = 0;
                    continue;
                end
                if (done_w[i]) begin
                    check("busy_low_at_done", i, 32'(busy_w[i]), 32'd0);
                    check("busy_cycles", i, 32'(busy_run[i]), 32'(LAT));
                    if (exp_q[i].size() == 0) begin
                        check("unexpected_done", i, 32'(done_w[i]), 32'd0);
                    end else begin
                        e = exp_q[i].pop_front();
                        $display("dut%0d value=%0d bcd=%h ovf=%0b (exp %h/%0b)",
                                 i, $signed(e.v), bcd_w[i], ovf_w[i], e.bcd, e.ovf);
                        check("bcd", i, bcd_w[i], e.bcd);
                        check("ovf", i, 32'(ovf_w[i]), 32'(e.ovf));
                        check("latency", i, 32'(cyc - e.acc_edge), 32'(LAT));
                    end
                end
                if (busy_w[i]) busy_run[i]++;
                else busy_run[i] = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_busy"}, i, 32'(busy_w[i]), 32'd0);
            check({tag, "_done"}, i, 32'(done_w[i]), 32'd0);
            check({tag, "_ovf"},  i, 32'(ovf_w[i]),  32'd0);
            check({tag, "_bcd"},  i, bcd_w[i], (i == 0) ? 32'h0000AAA0 : 32'h0);
        end
    endtask

    initial begin
        int dir_vals [13] = '{1234, -42, -7, 0, 12345, -1000, -32768, 5, 7, 42, 9999, -999, 10000};
        int first;
        int t;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Directed values from the feature list
        for (int k = 0; k < 13; k++) do_conv(DW'(dir_vals[k]));

        // start pulsed mid-conversion with a new value is ignored
        do_conv(DW'(-305));
        repeat (5) @(negedge clk);
        start = 1'b1;
        value = DW'(4321);
        @(negedge clk);
        start = 1'b0;
        value = DW'($urandom);

        // start held high: back-to-back conversions every PERIOD cycles
        wait_idle();
        start = 1'b1;
        first = cyc + 1;
        for (int k = 0; k <= 2 * PERIOD; k++) begin
            if (((cyc + 1 - first) % PERIOD) == 0) begin
                value = rand_val();
                push_exp(value);
            end else begin
                value = DW'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;

        // Randomized conversions
        for (int k = 0; k < 30; k++) do_conv(rand_val());

        // Reset during SHIFT after a saturated result
        do_conv(DW'(20000));
        do_conv(DW'(1234));
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        do_conv(DW'(-88));

        // Drain outstanding expectations
        t = 0;
        while ((exp_q[0].size() + exp_q[1].size()) != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain", 0, 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
